// File: rtl/conv_stream_pkg.sv
// conv_stream_pkg
//   Shared types and sizing helpers for the conv stream bridge.
//   state_t          : bridge FSM states
//   beats_per_frame  : beats in one square frame
//   cnt_width        : width of the per-frame beat/advance counters
package conv_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DRAIN
    } state_t;

    function automatic int beats_per_frame(input int image_dim, input int pixels_per_beat);
        return (image_dim * image_dim) / pixels_per_beat;
    endfunction

    // Wide enough for BEATS + PIPE_LATENCY advances without wrapping.
    function automatic int cnt_width(input int beats, input int pipe_latency);
        return $clog2(beats + pipe_latency) + 1;
    endfunction

endpackage

// File: rtl/conv_stream_bridge_if.sv
// conv_stream_bridge_if
//   AXI-Stream style beat channel used on both sides of the bridge.
//   tdata  : DW-bit beat
//   tvalid : beat valid (master -> slave)
//   tlast  : last beat of frame (master -> slave)
//   tready : beat accepted when tvalid & tready (slave -> master)
interface conv_stream_bridge_if #(
    parameter int DW = 128
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/conv_out_fifo.sv
// conv_out_fifo
//   Synchronous DW x DEPTH FIFO holding conv pipeline output beats.
//   clk, aresetn : clock, asynchronous active-low reset (pointers/count only)
//   push, push_data : write one beat (ignored when full)
//   pop, head       : head is the oldest entry; pop removes it (ignored when empty)
//   full, empty, count : occupancy status
//   DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
module conv_out_fifo #(
    parameter int DW    = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_stream_bridge.sv
// conv_stream_bridge
//   Flow-control front/back end for the stall-driven 3x3 Gaussian conv pipeline.
//   Accepts one frame of BEATS input beats, advances the pipeline one step per
//   accepted beat, then injects PIPE_LATENCY zero beats to flush it. Pipeline
//   output is collected (first PIPE_LATENCY advances discarded) into a small
//   FIFO and re-sent as AXI-Stream with tlast on the frame's last beat.
//   Ports:
//     clk, aresetn   : clock, asynchronous active-low reset
//     s_axis         : input beat stream (slave modport)
//     pipe_in_frame  : beat presented to the conv pipeline
//     pipe_stall     : 1 = conv pipeline holds all state
//     pipe_out_frame : conv pipeline output beat
//     m_axis         : output beat stream (master modport), registered
//     frame_err      : sticky tlast mismatch flag
//   Build option: define CONV_BRIDGE_TLAST_CHECK_EN to enable the input tlast
//   check driving frame_err; otherwise tlast is ignored and frame_err is 0.
module conv_stream_bridge
    import conv_stream_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int INPUT_WIDTH     = 8,
    parameter int IMAGE_DIM       = 512,
    parameter int PIPE_LATENCY    = 34,
    parameter int OUT_FIFO_DEPTH  = 4,
    localparam int DW             = INPUT_WIDTH * PIXELS_PER_BEAT
) (
    input  logic                 clk,
    input  logic                 aresetn,
    conv_stream_bridge_if.slave  s_axis,
    output logic [DW-1:0]        pipe_in_frame,
    output logic                 pipe_stall,
    input  logic [DW-1:0]        pipe_out_frame,
    conv_stream_bridge_if.master m_axis,
    output logic                 frame_err
);
    localparam int BEATS = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int CW    = cnt_width(BEATS, PIPE_LATENCY);
    localparam int FCW   = $clog2(OUT_FIFO_DEPTH) + 1;

    localparam logic [CW-1:0]  BEATS_C   = CW'(BEATS);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(BEATS - 1);
    localparam logic [CW-1:0]  LAT_C     = CW'(PIPE_LATENCY);
    localparam logic [CW-1:0]  ADV_LAST  = CW'(BEATS + PIPE_LATENCY - 1);
    localparam logic [FCW-1:0] DEPTH_C   = FCW'(OUT_FIFO_DEPTH);

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]  in_cnt_q;
    logic [CW-1:0]  adv_cnt_q;
    logic [CW-1:0]  out_cnt_q;

    logic           adv;
    logic           accept;
    logic           push;
    logic           pop;
    logic           fifo_room;
    logic           return_idle;

    logic [DW-1:0]  fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;

    logic [DW-1:0]  m_data_q;
    logic           m_valid_q;
    logic           m_last_q;

    // Pop only after counting the FIFO as it is now, so an advance never
    // relies on a same-cycle pop to make room.
    assign fifo_room = (fifo_count < DEPTH_C);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        adv           = 1'b0;
        s_axis.tready = 1'b0;
        pipe_in_frame = '0;
        case (state_q)
            IDLE: begin
                if (s_axis.tvalid) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                s_axis.tready = ~fifo_full;
                pipe_in_frame = s_axis.tdata;
                adv           = s_axis.tvalid & ~fifo_full & fifo_room;
                if (adv && (in_cnt_q == LAST_BEAT)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                adv = fifo_room;
                if (adv && (adv_cnt_q == ADV_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && (out_cnt_q == BEATS_C)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pipe_stall  = ~adv;
    assign accept      = adv & (state_q == STREAM);
    // pipe_out_frame at an advancing edge is the result of an earlier advance;
    // the first PIPE_LATENCY of them are pipeline fill, not frame data.
    assign push        = adv & (adv_cnt_q >= LAT_C);
    assign pop         = ~fifo_empty & (~m_valid_q | m_axis.tready);
    assign return_idle = (state_q == DRAIN) & (state_d == IDLE);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            in_cnt_q  <= '0;
            adv_cnt_q <= '0;
            out_cnt_q <= '0;
        end else if (return_idle) begin
            in_cnt_q  <= '0;
            adv_cnt_q <= '0;
            out_cnt_q <= '0;
        end else begin
            if (accept) begin
                in_cnt_q <= in_cnt_q + CW'(1);
            end
            if (adv) begin
                adv_cnt_q <= adv_cnt_q + CW'(1);
            end
            if (pop) begin
                out_cnt_q <= out_cnt_q + CW'(1);
            end
        end
    end

    conv_out_fifo #(
        .DW    (DW),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .aresetn   (aresetn),
        .push      (push),
        .push_data (pipe_out_frame),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Output register: loads from the FIFO head whenever it is free or being
    // accepted, and otherwise holds its beat unchanged.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (pop) begin
            m_data_q  <= fifo_head;
            m_valid_q <= 1'b1;
            m_last_q  <= (out_cnt_q == LAST_BEAT);
        end else if (m_axis.tready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end
    end

    assign m_axis.tdata  = m_data_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;

`ifdef CONV_BRIDGE_TLAST_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else if (accept && (s_axis.tlast != (in_cnt_q == LAST_BEAT))) begin
            err_q <= 1'b1;
        end
    end

    assign frame_err = err_q;
`else
    logic unused_tlast;

    assign unused_tlast = s_axis.tlast;
    assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_conv_stream_bridge.sv
`timescale 1ns/1ps
module tb_conv_stream_bridge;
    localparam int PPB   = 16;
    localparam int IW    = 8;
    localparam int DIM   = 64;
    localparam int LAT   = 6;
    localparam int DEPTH = 4;
    localparam int DW    = PPB * IW;
    localparam int BEATS = 256;

`ifdef CONV_BRIDGE_TLAST_CHECK_EN
    localparam bit TLAST_CHK = 1'b1;
`else
    localparam bit TLAST_CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] pipe_in_frame;
    logic [DW-1:0] pipe_out_frame;
    logic          pipe_stall;
    logic          frame_err;

    always #5 clk = ~clk;

    conv_stream_bridge_if #(.DW(DW)) s_if ();
    conv_stream_bridge_if #(.DW(DW)) m_if ();

    conv_stream_bridge #(
        .PIXELS_PER_BEAT (PPB),
        .INPUT_WIDTH     (IW),
        .IMAGE_DIM       (DIM),
        .PIPE_LATENCY    (LAT),
        .OUT_FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .s_axis         (s_if),
        .pipe_in_frame  (pipe_in_frame),
        .pipe_stall     (pipe_stall),
        .pipe_out_frame (pipe_out_frame),
        .m_axis         (m_if),
        .frame_err      (frame_err)
    );

    // Mock conv core: LAT-stage delay line that holds while stalled.
    logic [DW-1:0] pipe_q [LAT];
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else if (!pipe_stall) begin
            pipe_q[0] <= pipe_in_frame;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end
    assign pipe_out_frame = pipe_q[LAT-1];

    typedef struct {
        int         nframes;
        int         vpct;
        int         rpct;
        int         tlast_beat;
        logic [7:0] base;
        int         hold_at;
        int         hold_len;
        bit         exp_err;
        int         exp_out;
        int         exp_adv;
        int         exp_flush;
    } vec_t;

    vec_t vecs [5];
    int   tests = 0;
    int   fails = 0;

    // Never all-zero, so zero beats on pipe_in_frame are flush beats.
    function automatic logic [DW-1:0] beat_val(input int idx, input logic [7:0] base);
        logic [31:0] u;
        u = 32'(idx);
        return {u, ~u, {24'h5A5A5A, base}, u * 32'd3 + 32'd1};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk_int({tag, " s_tready"}, int'(s_if.tready), 0);
        chk_int({tag, " pipe_stall"}, int'(pipe_stall), 1);
        chk({tag, " pipe_in_frame"}, pipe_in_frame, '0);
        chk_int({tag, " m_tvalid"}, int'(m_if.tvalid), 0);
        chk_int({tag, " m_tlast"}, int'(m_if.tlast), 0);
        chk({tag, " m_tdata"}, m_if.tdata, '0);
        chk_int({tag, " frame_err"}, int'(frame_err), 0);
    endtask

    task automatic do_reset(input string tag);
        aresetn     = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals(tag);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input vec_t v, input string tag);
        int total, in_idx, out_idx, cyc, adv_n, zero_adv, full_bad, hold_cnt, hold_bad;
        bit holding, hold_done, acc;
        logic [DW-1:0] held;
        total = v.nframes * BEATS;
        in_idx = 0; out_idx = 0; cyc = 0; adv_n = 0; zero_adv = 0;
        full_bad = 0; hold_cnt = 0; hold_bad = 0;
        holding = 1'b0; hold_done = 1'b0; acc = 1'b1; held = '0;
        s_if.tvalid = 1'b0;
        while (out_idx < total && cyc < 20000) begin
            // tvalid is held until its beat is accepted
            if (acc || !s_if.tvalid)
                s_if.tvalid = (in_idx < total) && (int'($urandom_range(99)) < v.vpct);
            s_if.tdata = beat_val(in_idx, v.base);
            s_if.tlast = ((in_idx % BEATS) == v.tlast_beat);
            if (!hold_done && !holding && v.hold_at >= 0 && out_idx == v.hold_at)
                holding = 1'b1;
            m_if.tready = holding ? 1'b0 : (int'($urandom_range(99)) < v.rpct);
            @(negedge clk);
            if (!pipe_stall) begin
                adv_n++;
                if (pipe_in_frame == '0) zero_adv++;
            end
            if (dut.u_fifo.full && !pipe_stall) full_bad++;
            if (holding) begin
                if (hold_cnt == 0) held = m_if.tdata;
                else if (!m_if.tvalid || m_if.tdata !== held) hold_bad++;
                hold_cnt++;
                if (hold_cnt == v.hold_len) begin
                    chk({tag, " hold data"}, held, beat_val(v.hold_at, v.base));
                    chk_int({tag, " hold stall"}, int'(pipe_stall), 1);
                    // output reg 1 + FIFO 4 + pipeline 6 beyond the beats already sent
                    chk_int({tag, " hold inputs"}, in_idx, v.hold_at + 11);
                    chk_int({tag, " hold unstable"}, hold_bad, 0);
                    holding = 1'b0;
                    hold_done = 1'b1;
                end
            end
            acc = s_if.tvalid && s_if.tready;
            if (acc) in_idx++;
            if (m_if.tvalid && m_if.tready) begin
                chk($sformatf("%s data[%0d]", tag, out_idx), m_if.tdata, beat_val(out_idx, v.base));
                chk_int($sformatf("%s tlast[%0d]", tag, out_idx), int'(m_if.tlast),
                        int'((out_idx % BEATS) == BEATS - 1));
                out_idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk_int({tag, " outputs"}, out_idx, v.exp_out);
        chk_int({tag, " inputs"}, in_idx, v.exp_out);
        chk_int({tag, " advances"}, adv_n, v.exp_adv);
        chk_int({tag, " flush beats"}, zero_adv, v.exp_flush);
        chk_int({tag, " advance while full"}, full_bad, 0);
        chk_int({tag, " frame_err"}, int'(frame_err), int'(v.exp_err));
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_int({tag, " idle m_tvalid"}, int'(m_if.tvalid), 0);
        chk_int({tag, " idle pipe_stall"}, int'(pipe_stall), 1);
    endtask

    initial begin
        vec_t h;
        int   k, cyc;

        vecs[0] = '{nframes:1, vpct:100, rpct:100, tlast_beat:255, base:8'h01, hold_at:-1,
                    hold_len:0, exp_err:1'b0, exp_out:256, exp_adv:262, exp_flush:6};
        vecs[1] = '{nframes:1, vpct:50, rpct:30, tlast_beat:255, base:8'h02, hold_at:-1,
                    hold_len:0, exp_err:1'b0, exp_out:256, exp_adv:262, exp_flush:6};
        vecs[2] = '{nframes:1, vpct:100, rpct:100, tlast_beat:10, base:8'h03, hold_at:-1,
                    hold_len:0, exp_err:TLAST_CHK, exp_out:256, exp_adv:262, exp_flush:6};
        vecs[3] = '{nframes:2, vpct:100, rpct:100, tlast_beat:255, base:8'h04, hold_at:-1,
                    hold_len:0, exp_err:1'b0, exp_out:512, exp_adv:524, exp_flush:12};
        vecs[4] = '{nframes:1, vpct:80, rpct:70, tlast_beat:255, base:8'h05, hold_at:-1,
                    hold_len:0, exp_err:1'b0, exp_out:256, exp_adv:262, exp_flush:6};

        for (int i = 0; i < 5; i++) begin
            do_reset($sformatf("v%0d reset", i));
            run_stream(vecs[i], $sformatf("v%0d", i));
        end

        // Downstream stalled for 100 cycles mid-frame.
        h = '{nframes:1, vpct:100, rpct:100, tlast_beat:255, base:8'h3C, hold_at:50,
              hold_len:100, exp_err:1'b0, exp_out:256, exp_adv:262, exp_flush:6};
        do_reset("hold reset");
        run_stream(h, "hold");

        // Reset asserted mid-frame, then a fresh frame.
        do_reset("mid pre");
        k = 0;
        cyc = 0;
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        while (k < 100 && cyc < 2000) begin
            s_if.tdata = beat_val(k, 8'hEE);
            @(negedge clk);
            if (s_if.tvalid && s_if.tready) k++;
            if (k < 100) begin
                @(posedge clk);
                #1;
            end
            cyc++;
        end
        chk_int("mid beats before reset", k, 100);
        chk_int("mid m_tvalid before reset", int'(m_if.tvalid), 1);
        aresetn = 1'b0;
        #1;
        check_reset_vals("mid async");
        s_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        h = '{nframes:1, vpct:100, rpct:100, tlast_beat:255, base:8'h33, hold_at:-1,
              hold_len:0, exp_err:1'b0, exp_out:256, exp_adv:262, exp_flush:6};
        run_stream(h, "after mid reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
